// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding data-memory load/store sequencer with byte/half/word lanes.
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses complete without a bus request and raise o_misaligned.
`default_nettype none

module load_store_unit (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [1:0]  i_d_size,
    input  logic        i_d_unsigned,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_misaligned,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_gnt,
    input  logic        i_bus_rvalid,
    input  logic [31:0] i_bus_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_next;

    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [1:0]  r_off;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    logic        w_req;
    logic        w_capture;
    logic [1:0]  w_size;
    logic [1:0]  w_off;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [31:0] w_load;

    assign w_req     = i_mem_read | i_mem_write;
    assign w_capture = (r_state == S_IDLE) && w_req;
    // Reserved size code behaves as a word access.
    assign w_size    = (i_d_size == 2'b11) ? SZ_WORD : i_d_size;

    always_comb begin
        w_off   = i_addr[1:0];
        w_be    = 4'b1111;
        w_wdata = i_wdata;
        case (w_size)
            SZ_BYTE: begin
                w_off   = i_addr[1:0];
                w_be    = 4'b0001 << i_addr[1:0];
                w_wdata = {4{i_wdata[7:0]}};
            end
            SZ_HALF: begin
                w_off   = {i_addr[1], 1'b0};
                w_be    = 4'b0011 << {i_addr[1], 1'b0};
                w_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                w_off   = 2'b00;
                w_be    = 4'b1111;
                w_wdata = i_wdata;
            end
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misalign;
    logic r_misaligned;

    assign w_misalign = ((w_size == SZ_HALF) && i_addr[0]) ||
                        ((w_size == SZ_WORD) && (i_addr[1:0] != 2'b00));
`endif

    // Load lane extraction uses the captured (already aligned) offset.
    assign w_shifted = i_bus_rdata >> {r_off, 3'b000};

    always_comb begin
        w_load = w_shifted;
        case (r_size)
            SZ_BYTE: w_load = {{24{~r_uns & w_shifted[7]}}, w_shifted[7:0]};
            SZ_HALF: w_load = {{16{~r_uns & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    w_next = w_misalign ? S_RESP : S_REQ;
`else
                    w_next = S_REQ;
`endif
                end
            end
            S_REQ: begin
                if (i_bus_gnt) begin
                    w_next = r_we ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_bus_rvalid) begin
                    w_next = S_RESP;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_stall   = w_capture || (r_state == S_REQ) || (r_state == S_WAIT);
        o_done    = (r_state == S_RESP);
        o_bus_req = (r_state == S_REQ);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr  <= '0;
            r_size  <= SZ_BYTE;
            r_uns   <= 1'b0;
            r_off   <= 2'b00;
            r_we    <= 1'b0;
            r_be    <= 4'b0000;
            r_wdata <= '0;
            r_rdata <= '0;
        end else if (w_capture) begin
            r_addr  <= {i_addr[31:2], 2'b00};
            r_size  <= w_size;
            r_uns   <= i_d_unsigned;
            r_off   <= w_off;
            r_we    <= i_mem_write;
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_rdata <= '0;
        end else if ((r_state == S_WAIT) && i_bus_rvalid) begin
            r_rdata <= w_load;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_misaligned <= 1'b0;
        end else if (w_capture) begin
            r_misaligned <= w_misalign;
        end
    end

    assign o_misaligned = r_misaligned && (r_state == S_RESP);
`else
    assign o_misaligned = 1'b0;
`endif

    assign o_rdata     = r_rdata;
    assign o_bus_we    = r_we;
    assign o_bus_addr  = r_addr;
    assign o_bus_be    = r_be;
    assign o_bus_wdata = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scenarios plus randomized transactions checked against a byte-lane reference model.
`default_nettype none

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_mem_read, i_mem_write;
    logic [1:0]  i_d_size;
    logic        i_d_unsigned;
    logic [31:0] i_addr, i_wdata;
    logic        o_stall, o_done, o_misaligned;
    logic [31:0] o_rdata;
    logic        o_bus_req, o_bus_we;
    logic [31:0] o_bus_addr, o_bus_wdata;
    logic [3:0]  o_bus_be;
    logic        i_bus_gnt, i_bus_rvalid;
    logic [31:0] i_bus_rdata;

    int checks = 0;
    int errors = 0;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    load_store_unit dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_mem_read   (i_mem_read),
        .i_mem_write  (i_mem_write),
        .i_d_size     (i_d_size),
        .i_d_unsigned (i_d_unsigned),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_stall      (o_stall),
        .o_done       (o_done),
        .o_rdata      (o_rdata),
        .o_misaligned (o_misaligned),
        .o_bus_req    (o_bus_req),
        .o_bus_we     (o_bus_we),
        .o_bus_addr   (o_bus_addr),
        .o_bus_be     (o_bus_be),
        .o_bus_wdata  (o_bus_wdata),
        .i_bus_gnt    (i_bus_gnt),
        .i_bus_rvalid (i_bus_rvalid),
        .i_bus_rdata  (i_bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: access width in bytes, naturally aligned offset, lanes.
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic int raw_off(input logic [31:0] a);
        return int'(a % 4);
    endfunction

    function automatic bit model_mis(input logic [31:0] a, input logic [1:0] sz);
        return (raw_off(a) % nbytes(sz)) != 0;
    endfunction

    function automatic int model_off(input logic [31:0] a, input logic [1:0] sz);
        return raw_off(a) - (raw_off(a) % nbytes(sz));
    endfunction

    function automatic logic [3:0] model_be(input logic [31:0] a, input logic [1:0] sz);
        int m;
        m = ((1 << nbytes(sz)) - 1) << model_off(a, sz);
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [1:0] sz);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes(sz)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a,
                                               input logic [1:0] sz, input bit uns);
        logic [31:0] v, mask;
        int nb;
        nb = nbytes(sz);
        v  = rd >> (8 * model_off(a, sz));
        if (nb < 4) begin
            mask = (32'h1 << (8 * nb)) - 32'h1;
            v    = v & mask;
            if (!uns && v[8*nb-1]) v = v | ~mask;
        end
        return v;
    endfunction

    task automatic txn(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                       input int gd, input int rvd, input string tag);
        bit          we, trap;
        int          cyc, req_seen, wait_seen, dones, done_cyc, exp_lat;
        logic [31:0] exp_rd;
        we      = wr;
        trap    = TRAP && model_mis(addr, sz);
        exp_rd  = (we || trap) ? 32'h0 : model_load(rdata, addr, sz, uns);
        exp_lat = trap ? 2 : we ? 3 + gd : 4 + gd + rvd;
        req_seen = 0; wait_seen = 0; dones = 0; done_cyc = 0;
        @(negedge clk);
        i_mem_read = rd; i_mem_write = wr; i_d_size = sz; i_d_unsigned = uns;
        i_addr = addr; i_wdata = wdata;
        #1 chk({tag, " stall_idle"}, 32'(o_stall), 32'd1);
        cyc = 1;
        while (dones == 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            i_mem_read = 1'b0; i_mem_write = 1'b0;
            i_addr = $urandom; i_wdata = $urandom;
            i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = $urandom;
            if (o_done) begin
                dones++;
                done_cyc = cyc;
                chk({tag, " rdata"}, o_rdata, exp_rd);
                chk({tag, " misaligned"}, 32'(o_misaligned), 32'(trap));
                chk({tag, " stall_resp"}, 32'(o_stall), 32'd0);
                chk({tag, " req_resp"}, 32'(o_bus_req), 32'd0);
            end else if (o_bus_req) begin
                req_seen++;
                chk({tag, " bus_addr"}, o_bus_addr, {addr[31:2], 2'b00});
                chk({tag, " bus_be"}, 32'(o_bus_be), 32'(model_be(addr, sz)));
                chk({tag, " bus_we"}, 32'(o_bus_we), 32'(we));
                if (we) chk({tag, " bus_wdata"}, o_bus_wdata, model_wdata(wdata, sz));
                chk({tag, " stall_req"}, 32'(o_stall), 32'd1);
                i_bus_rvalid = 1'($urandom);
                if (req_seen > gd) i_bus_gnt = 1'b1;
            end else begin
                wait_seen++;
                chk({tag, " stall_wait"}, 32'(o_stall), 32'd1);
                if (wait_seen > rvd) begin
                    i_bus_rvalid = 1'b1;
                    i_bus_rdata  = rdata;
                end
            end
        end
        if (dones == 0) chk({tag, " timeout"}, 32'd0, 32'd1);
        else chk({tag, " latency"}, 32'(done_cyc), 32'(exp_lat));
        chk({tag, " req_cycles"}, 32'(req_seen), trap ? 32'd0 : 32'(gd + 1));
        @(negedge clk);
        i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0;
        chk({tag, " single_done"}, 32'(o_done), 32'd0);
        chk({tag, " stall_after"}, 32'(o_stall), 32'd0);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, " stall"}, 32'(o_stall), 32'd0);
        chk({tag, " done"}, 32'(o_done), 32'd0);
        chk({tag, " rdata"}, o_rdata, 32'd0);
        chk({tag, " mis"}, 32'(o_misaligned), 32'd0);
        chk({tag, " req"}, 32'(o_bus_req), 32'd0);
        chk({tag, " we"}, 32'(o_bus_we), 32'd0);
        chk({tag, " addr"}, o_bus_addr, 32'd0);
        chk({tag, " be"}, 32'(o_bus_be), 32'd0);
        chk({tag, " wdata"}, o_bus_wdata, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        i_mem_read = 1'b0; i_mem_write = 1'b0; i_d_size = 2'd0; i_d_unsigned = 1'b0;
        i_addr = 32'h0; i_wdata = 32'h0;
        i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk_cleared("reset");
        #2 rst = 1'b0;

        txn(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 0, "SW");
        txn(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0203, 32'h0, 32'h80FF_FF00, 0, 0, "LB_s");
        txn(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0203, 32'h0, 32'h80FF_FF00, 0, 0, "LB_u");
        txn(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0042, 32'h1234_ABCD, 32'h0, 0, 0, "SH");
        txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 3, 2, "WAITS");
        txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0, 32'hA1B2_C3D4, 0, 0, "LW_mis");
        txn(1'b1, 1'b1, 2'd3, 1'b0, 32'h0000_0208, 32'h0BAD_CAFE, 32'h0, 1, 0, "RW_both");

        // Reset while a store waits for grant.
        @(negedge clk);
        i_mem_write = 1'b1; i_d_size = 2'd2; i_addr = 32'h0000_0500; i_wdata = 32'h5555_AAAA;
        @(negedge clk);
        i_mem_write = 1'b0;
        chk("rst_req bus_req", 32'(o_bus_req), 32'd1);
        #2 rst = 1'b1;
        #1 chk_cleared("rst_req");
        @(negedge clk);
        #2 rst = 1'b0;

        // Reset in WAIT, then a late response must be ignored.
        @(negedge clk);
        i_mem_read = 1'b1; i_d_size = 2'd2; i_addr = 32'h0000_0300;
        @(negedge clk);
        i_mem_read = 1'b0; i_bus_gnt = 1'b1;
        chk("rst_wait bus_req", 32'(o_bus_req), 32'd1);
        @(negedge clk);
        i_bus_gnt = 1'b0;
        chk("rst_wait stall", 32'(o_stall), 32'd1);
        #2 rst = 1'b1;
        #1 chk_cleared("rst_wait");
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        i_bus_rvalid = 1'b1; i_bus_rdata = 32'h1234_5678;
        repeat (2) begin
            @(negedge clk);
            chk("late_rvalid done", 32'(o_done), 32'd0);
            chk("late_rvalid rdata", o_rdata, 32'd0);
        end
        i_bus_rvalid = 1'b0;

        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = int'($urandom_range(0, 2));
            txn(kind != 1, kind != 0, 2'($urandom_range(0, 3)), 1'($urandom),
                $urandom, $urandom, $urandom,
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), "RAND");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
